// File: rtl/hv_efuse_load_ctrl_if.sv
// hv_efuse_load_ctrl_if: load handshake, efuse macro read port and register-file write bundle.
interface hv_efuse_load_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              i_efuse_load_req;
  logic              o_efuse_load_done;
  logic              o_efuse_busy;
  logic              o_efuse_csb;
  logic              o_efuse_strobe;
  logic [ADDR_W-1:0] o_efuse_addr;
  logic [DATA_W-1:0] i_efuse_dout;
  logic              o_reg_wr_en;
  logic [ADDR_W-1:0] o_reg_wr_addr;
  logic [DATA_W-1:0] o_reg_wr_data;
  logic              o_efuse_vld;
  logic              o_efuse_chk_err;
  modport slave (
    input  i_efuse_load_req, i_efuse_dout,
    output o_efuse_load_done, o_efuse_busy, o_efuse_csb, o_efuse_strobe, o_efuse_addr,
           o_reg_wr_en, o_reg_wr_addr, o_reg_wr_data, o_efuse_vld, o_efuse_chk_err
  );
  modport master (
    output i_efuse_load_req, i_efuse_dout,
    input  o_efuse_load_done, o_efuse_busy, o_efuse_csb, o_efuse_strobe, o_efuse_addr,
           o_reg_wr_en, o_reg_wr_addr, o_reg_wr_data, o_efuse_vld, o_efuse_chk_err
  );
endinterface

// File: rtl/hv_efuse_load_ctrl.sv
// hv_efuse_load_ctrl: sequences efuse word reads into the register file and validates the XOR checksum.
// Define HV_EFUSE_DBL_READ_EN to read every word twice and reject the load on any read mismatch.
module hv_efuse_load_ctrl #(
  parameter int EFUSE_WORD_NUM = 8,
  parameter int EFUSE_DATA_W   = 8,
  parameter int EFUSE_ADDR_W   = 3,
  parameter int RD_SETUP_CYC   = 2,
  parameter int RD_PULSE_CYC   = 4,
  parameter int RD_HOLD_CYC    = 2
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  hv_efuse_load_ctrl_if.slave b
);
  localparam int MAX_CYC = RD_SETUP_CYC > RD_PULSE_CYC ?
                           (RD_SETUP_CYC > RD_HOLD_CYC ? RD_SETUP_CYC : RD_HOLD_CYC) :
                           (RD_PULSE_CYC > RD_HOLD_CYC ? RD_PULSE_CYC : RD_HOLD_CYC);
  localparam int CNT_W = MAX_CYC > 1 ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(RD_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(RD_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(RD_HOLD_CYC - 1);
  localparam logic [EFUSE_ADDR_W-1:0] LAST_IDX = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WRITE, CHECK, DONE} state_t;
  state_t                  r_state;
  logic                    r_armed;
  logic [EFUSE_ADDR_W-1:0] r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [EFUSE_DATA_W-1:0] r_cap;
  logic [EFUSE_DATA_W-1:0] r_acc;
  logic                    r_nz;
  logic                    r_csb;
  logic                    r_strobe;
  logic                    r_wr_en;
  logic                    r_done;
  logic                    r_busy;
  logic                    r_vld;
  logic                    r_err;
  logic                    w_pass;
`ifdef HV_EFUSE_DBL_READ_EN
  logic                    r_second;
  logic                    r_mis;
  assign w_pass = ~|r_acc & r_nz & ~r_mis;
`else
  assign w_pass = ~|r_acc & r_nz;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_armed  <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_cap    <= '0;
      r_acc    <= '0;
      r_nz     <= 1'b0;
      r_csb    <= 1'b1;
      r_strobe <= 1'b0;
      r_wr_en  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_vld    <= 1'b0;
      r_err    <= 1'b0;
`ifdef HV_EFUSE_DBL_READ_EN
      r_second <= 1'b0;
      r_mis    <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          // armed only re-arms after req is seen low, so a lingering req cannot retrigger
          if (b.i_efuse_load_req && r_armed) begin
            r_state <= SETUP;
            r_armed <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= SETUP_LD;
            r_csb   <= 1'b0;
            r_busy  <= 1'b1;
            r_vld   <= 1'b0;
            r_err   <= 1'b0;
            r_acc   <= '0;
            r_nz    <= 1'b0;
`ifdef HV_EFUSE_DBL_READ_EN
            r_second <= 1'b0;
            r_mis    <= 1'b0;
`endif
          end else if (!b.i_efuse_load_req) begin
            r_armed <= 1'b1;
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_state  <= PULSE;
            r_cnt    <= PULSE_LD;
            r_strobe <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        PULSE: begin
          if (r_cnt == '0) begin
            r_state  <= HOLD;
            r_cnt    <= HOLD_LD;
            r_strobe <= 1'b0;
`ifdef HV_EFUSE_DBL_READ_EN
            if (r_second) r_mis <= r_mis | (b.i_efuse_dout != r_cap);
            else r_cap <= b.i_efuse_dout;
`else
            r_cap <= b.i_efuse_dout;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (r_cnt == '0) begin
`ifdef HV_EFUSE_DBL_READ_EN
            if (!r_second) begin
              r_state  <= SETUP;
              r_cnt    <= SETUP_LD;
              r_second <= 1'b1;
            end else begin
              r_state  <= WRITE;
              r_second <= 1'b0;
              r_csb    <= 1'b1;
              r_wr_en  <= 1'b1;
            end
`else
            r_state <= WRITE;
            r_csb   <= 1'b1;
            r_wr_en <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WRITE: begin
          r_acc <= r_acc ^ r_cap;
          r_nz  <= r_nz | (|r_cap);
          if (r_idx == LAST_IDX) begin
            r_state <= CHECK;
          end else begin
            r_state <= SETUP;
            r_idx   <= r_idx + 1'b1;
            r_cnt   <= SETUP_LD;
            r_csb   <= 1'b0;
          end
        end
        CHECK: begin
          r_state <= DONE;
          r_vld   <= w_pass;
          r_err   <= ~w_pass;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign b.o_efuse_load_done = r_done;
  assign b.o_efuse_busy      = r_busy;
  assign b.o_efuse_csb       = r_csb;
  assign b.o_efuse_strobe    = r_strobe;
  assign b.o_efuse_addr      = r_idx;
  assign b.o_reg_wr_en       = r_wr_en;
  assign b.o_reg_wr_addr     = r_idx;
  assign b.o_reg_wr_data     = r_cap;
  assign b.o_efuse_vld       = r_vld;
  assign b.o_efuse_chk_err   = r_err;
endmodule

// File: tb/tb_hv_efuse_load_ctrl.sv
// tb_hv_efuse_load_ctrl: scoreboarded bench for the efuse load responder.
module tb_hv_efuse_load_ctrl;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int NW = 8;
`ifdef HV_EFUSE_DBL_READ_EN
  localparam int PER_WORD = 2 * (2 + 4 + 2) + 1;
`else
  localparam int PER_WORD = 2 + 4 + 2 + 1;
`endif
  localparam int DONE_CYC = 1 + NW * PER_WORD + 1;
  localparam logic [63:0] GOOD  = 64'h0F_40_20_10_08_44_22_11;
  localparam logic [63:0] BAD_A = 64'h7F_40_20_10_08_44_22_11;
  localparam logic [63:0] BAD_B = 64'h0E_40_20_10_08_44_22_11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mem [NW];
  logic flip_arm = 1'b0;
  logic [AW+DW-1:0] q [$];
  hv_efuse_load_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  hv_efuse_load_ctrl #(
    .EFUSE_WORD_NUM(NW), .EFUSE_DATA_W(DW), .EFUSE_ADDR_W(AW),
    .RD_SETUP_CYC(2), .RD_PULSE_CYC(4), .RD_HOLD_CYC(2)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .b      (bus)
  );
  always #5 clk = ~clk;
  // macro model: data only meaningful while strobe is high
  assign bus.i_efuse_dout = bus.o_efuse_strobe ? mem[bus.o_efuse_addr] : 8'hA5;
  always @(negedge bus.o_efuse_strobe)
    if (flip_arm && bus.o_efuse_addr == 3'd1) mem[1] = 8'h23;
  task automatic load_mem(input logic [63:0] w);
    for (int i = 0; i < NW; i++) mem[i] = w[i*8 +: 8];
  endtask
  task automatic run_load(input string name, input logic [63:0] w, input logic exp_vld, input int hold);
    int cyc;
    int done_cyc;
    int bad_hold;
    logic [AW+DW-1:0] e;
    cyc = 0;
    done_cyc = -1;
    bad_hold = 0;
    load_mem(w);
    q.delete();
    for (int i = 0; i < NW; i++) q.push_back({AW'(i), w[i*8 +: 8]});
    bus.i_efuse_load_req = 1'b1;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.o_reg_wr_en) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL %s wr_extra addr=%0d data=%h", name, bus.o_reg_wr_addr, bus.o_reg_wr_data);
        end else begin
          e = q.pop_front();
          if ({bus.o_reg_wr_addr, bus.o_reg_wr_data} !== e)
            begin failures++; $display("FAIL %s wr got addr=%0d data=%h exp addr=%0d data=%h", name, bus.o_reg_wr_addr, bus.o_reg_wr_data, e[AW+DW-1:DW], e[DW-1:0]); end
        end
      end
      if (bus.o_efuse_load_done) done_cyc = cyc;
    end
    checks++;
    if (done_cyc !== DONE_CYC) begin failures++; $display("FAIL %s done_cycle got %0d exp %0d", name, done_cyc, DONE_CYC); end
    checks++;
    if (bus.o_efuse_vld !== exp_vld) begin failures++; $display("FAIL %s vld got %b exp %b", name, bus.o_efuse_vld, exp_vld); end
    checks++;
    if (bus.o_efuse_chk_err !== ~exp_vld) begin failures++; $display("FAIL %s chk_err got %b exp %b", name, bus.o_efuse_chk_err, ~exp_vld); end
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL %s missing_writes got %0d exp 0", name, q.size()); end
    q.delete();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.o_efuse_busy || bus.o_efuse_load_done || bus.o_efuse_vld !== exp_vld) bad_hold++;
    end
    if (hold > 0) begin
      checks++;
      if (bad_hold != 0) begin failures++; $display("FAIL %s hold_after_done bad_cycles got %0d exp 0", name, bad_hold); end
    end
    bus.i_efuse_load_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset();
    bus.i_efuse_load_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.o_efuse_csb, bus.o_efuse_strobe, bus.o_efuse_busy, bus.o_efuse_load_done, bus.o_reg_wr_en, bus.o_efuse_vld, bus.o_efuse_chk_err} !== 7'b1000000)
      begin failures++; $display("FAIL reset_ctrl got csb/stb/busy/done/wr/vld/err=%b exp 1000000", {bus.o_efuse_csb, bus.o_efuse_strobe, bus.o_efuse_busy, bus.o_efuse_load_done, bus.o_reg_wr_en, bus.o_efuse_vld, bus.o_efuse_chk_err}); end
    checks++;
    if ({bus.o_efuse_addr, bus.o_reg_wr_data} !== '0) begin failures++; $display("FAIL reset_bus got addr=%0d data=%h exp 0", bus.o_efuse_addr, bus.o_reg_wr_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_checksum();
    run_load("good", GOOD, 1'b1, 0);
    run_load("bad_7f", BAD_A, 1'b0, 0);
    run_load("bad_0e", BAD_B, 1'b0, 0);
    run_load("blank", 64'h0, 1'b0, 0);
  endtask
  task automatic test_no_restart();
    run_load("held_req", GOOD, 1'b1, 10);
    run_load("rearm", GOOD, 1'b1, 0);
  endtask
  task automatic test_reset_mid();
    int cyc;
    int writes;
    int bad;
    cyc = 0;
    writes = 0;
    bad = 0;
    load_mem(GOOD);
    bus.i_efuse_load_req = 1'b1;
    while (!(bus.o_efuse_addr == 3'd3 && bus.o_efuse_strobe) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.o_reg_wr_en) writes++;
    end
    checks++;
    if (!(bus.o_efuse_addr == 3'd3 && bus.o_efuse_strobe)) begin failures++; $display("FAIL rst_mid wait_pulse3 got timeout exp pulse"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_efuse_csb, bus.o_efuse_strobe, bus.o_efuse_busy, bus.o_efuse_vld} !== 4'b1000)
      begin failures++; $display("FAIL rst_mid async got csb/stb/busy/vld=%b exp 1000", {bus.o_efuse_csb, bus.o_efuse_strobe, bus.o_efuse_busy, bus.o_efuse_vld}); end
    checks++;
    if (writes != 3) begin failures++; $display("FAIL rst_mid writes_before got %0d exp 3", writes); end
    bus.i_efuse_load_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_efuse_load_done || bus.o_efuse_busy) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rst_mid idle_after got %0d active cycles exp 0", bad); end
    run_load("reload", GOOD, 1'b1, 0);
  endtask
`ifdef HV_EFUSE_DBL_READ_EN
  task automatic test_dbl_read();
    flip_arm = 1'b1;
    run_load("dbl_mismatch", GOOD, 1'b0, 0);
    flip_arm = 1'b0;
    run_load("dbl_clean", GOOD, 1'b1, 0);
  endtask
`endif
  initial begin
    test_reset();
    test_checksum();
    test_no_restart();
    test_reset_mid();
`ifdef HV_EFUSE_DBL_READ_EN
    test_dbl_read();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
